// File: rtl/uart_digit_reporter_pkg.sv
// Shared constants, state encoding and byte selection for the digit reporter.
package uart_digit_reporter_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StSend,
        StWaitDone
    } state_e;

    // Byte for a given output index: four ASCII digits, most significant first, then CR, LF.
    function automatic logic [7:0] byte_for_index(input logic [IDX_W-1:0] idx,
                                                  input logic [BCD_W-1:0] bcd);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_ZERO + {4'h0, bcd[15:12]};
            3'd1:    b = ASCII_ZERO + {4'h0, bcd[11:8]};
            3'd2:    b = ASCII_ZERO + {4'h0, bcd[7:4]};
            3'd3:    b = ASCII_ZERO + {4'h0, bcd[3:0]};
            3'd4:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_digit_reporter_bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, DIGIT_WIDTH shifts per conversion.
// The first shift happens on the start edge, so o_done is high in the last of the
// DIGIT_WIDTH conversion cycles and o_bcd is already final in that cycle.
module bin2bcd_seq
    import uart_digit_reporter_pkg::*;
#(
    parameter int unsigned DIGIT_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [DIGIT_WIDTH-1:0] i_bin,
    output logic [BCD_W-1:0]       o_bcd,
    output logic                   o_done
);

    localparam int unsigned CNT_W = $clog2(DIGIT_WIDTH + 1);

    logic [DIGIT_WIDTH-1:0] sr_q, sr_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [NIBBLE_W-1:0]    nib;

    // Add 3 to every nibble >= 5 ahead of the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        nib     = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            nib = bcd_q[i*NIBBLE_W +: NIBBLE_W];
            bcd_adj[i*NIBBLE_W +: NIBBLE_W] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    // Next-state: load and first shift on start, then shift until the counter empties.
    always_comb begin
        sr_d   = sr_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (i_start) begin
            // BCD starts at zero, so no adjust is needed before this first shift.
            bcd_d  = BCD_W'(i_bin[DIGIT_WIDTH-1]);
            sr_d   = i_bin << 1;
            cnt_d  = CNT_W'(DIGIT_WIDTH - 1);
            done_d = (DIGIT_WIDTH == 1);
        end else if (cnt_q != '0) begin
            bcd_d  = {bcd_adj[BCD_W-2:0], sr_q[DIGIT_WIDTH-1]};
            sr_d   = sr_q << 1;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    // Conversion state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        o_bcd  = bcd_q;
        o_done = done_q;
    end

endmodule

// File: rtl/uart_digit_reporter.sv
// Samples the counter on a trigger, converts it to ASCII decimal and streams the bytes
// into the UART transmitter through its start / tx_done handshake.
module uart_digit_reporter
    import uart_digit_reporter_pkg::*;
#(
    parameter int unsigned DIGIT_WIDTH = 14,
    parameter int unsigned MAX_VALUE   = 9999,
    parameter bit          SEND_CRLF   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_trigger,
    input  logic [DIGIT_WIDTH-1:0] i_digit,
    input  logic                   i_tx_done,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    output logic                   o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = SEND_CRLF ? 3'd5 : 3'd3;

    state_e             state_q, state_d;
    logic               pending_q, pending_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
    logic [7:0]         data_q, data_d;
    logic               busy_q, busy_d;

    logic [DIGIT_WIDTH-1:0] clamped;
    logic                   conv_start;
    logic                   conv_done;
    logic [BCD_W-1:0]       bcd;

    // Saturate the sampled value so it always fits four decimal digits.
    always_comb begin
        clamped = (i_digit > DIGIT_WIDTH'(MAX_VALUE)) ? DIGIT_WIDTH'(MAX_VALUE) : i_digit;
    end

    bin2bcd_seq #(
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (conv_start),
        .i_bin   (clamped),
        .o_bcd   (bcd),
        .o_done  (conv_done)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; tx data is loaded only on the transition into StSend.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        idx_d      = idx_q;
        data_d     = data_q;
        conv_start = 1'b0;
        idx_inc    = idx_q + 3'd1;

        // Triggers while busy collapse into one pending report.
        if (state_q != StIdle && i_trigger) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_trigger) begin
                    conv_start = 1'b1;
                    state_d    = StConvert;
                end
            end
            StConvert: begin
                if (conv_done) begin
                    idx_d   = '0;
                    data_d  = byte_for_index('0, bcd);
                    state_d = StSend;
                end
            end
            StSend: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // A trigger coinciding with the final done still counts.
                        if (pending_q || i_trigger) begin
                            pending_d  = 1'b0;
                            conv_start = 1'b1;
                            state_d    = StConvert;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d   = idx_inc;
                        data_d  = byte_for_index(idx_inc, bcd);
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // Outputs: start is a one-cycle pulse tied to StSend.
    always_comb begin
        o_tx_start = (state_q == StSend);
        o_tx_data  = data_q;
        o_busy     = busy_q;
    end

endmodule

// File: tb/tb_uart_digit_reporter.sv
// Self-checking bench for uart_digit_reporter with a scoreboard of expected bytes.
module tb_uart_digit_reporter;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig, tx_done;
    logic [13:0] digit;
    logic        start, busy;
    logic [7:0]  data;

    logic        trig2, done2;
    logic [13:0] digit2;
    logic        start2, busy2;
    logic [7:0]  data2;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int start_cnt2 = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    uart_digit_reporter dut (
        .clk        (clk),
        .reset      (reset),
        .i_trigger  (trig),
        .i_digit    (digit),
        .i_tx_done  (tx_done),
        .o_tx_start (start),
        .o_tx_data  (data),
        .o_busy     (busy)
    );

    uart_digit_reporter #(
        .SEND_CRLF (1'b0)
    ) dut_nocrlf (
        .clk        (clk),
        .reset      (reset),
        .i_trigger  (trig2),
        .i_digit    (digit2),
        .i_tx_done  (done2),
        .o_tx_start (start2),
        .o_tx_data  (data2),
        .o_busy     (busy2)
    );

    always @(negedge clk) begin
        if (start)  start_cnt++;
        if (start2) start_cnt2++;
    end

    // Reference model: clamp, split into decimal digits, append CR/LF if enabled.
    function automatic void push_expected(input int val, input bit crlf);
        int v;
        v = (val > 9999) ? 9999 : val;
        exp_q.push_back(8'(8'h30 + v / 1000));
        exp_q.push_back(8'(8'h30 + (v / 100) % 10));
        exp_q.push_back(8'(8'h30 + (v / 10) % 10));
        exp_q.push_back(8'(8'h30 + v % 10));
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    // Pulse trigger for one cycle; returns #1 into the cycle after the trigger cycle.
    task automatic fire();
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
    endtask

    // UART model: waits for each start, records the byte, answers tx_done `delay` cycles later.
    task automatic serve(input int nbytes, input int delay, input bit trig_last,
                         output int lat, output bit all_seen, output bit hold_ok,
                         output bit busy_last);
        int n;
        bit seen;
        logic [7:0] held;
        lat = -1; all_seen = 1'b1; hold_ok = 1'b1; busy_last = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            n = 0; seen = 1'b0;
            while (n < 3000 && !seen) begin
                @(negedge clk);
                if (start) seen = 1'b1;
                else n++;
            end
            if (!seen) begin
                all_seen = 1'b0;
                return;
            end
            if (i == 0) lat = n + 1;
            held = data;
            got_q.push_back(data);
            for (int k = 1; k < delay; k++) begin
                @(negedge clk);
                if (start || data !== held) hold_ok = 1'b0;
            end
            @(posedge clk); #1;
            tx_done = 1'b1;
            if (trig_last && i == nbytes - 1) trig = 1'b1;
            @(negedge clk);
            busy_last = busy;
            @(posedge clk); #1;
            tx_done = 1'b0;
            trig = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (busy2 !== 1'b0 || start2 !== 1'b0) begin
            errors++; $display("FAIL reset_nocrlf: got busy=%b start=%b want 0 0", busy2, start2);
        end
    endtask

    task automatic test_basic();
        int lat; bit seen, hold, bl;
        logic [7:0] e, g;
        digit = 14'd42;
        push_expected(42, 1'b1);
        fire();
        serve(6, 10, 1'b0, lat, seen, hold, bl);
        @(negedge clk);
        checks++; if (!seen) begin errors++; $display("FAIL basic_seen: got missing start want 6 bytes"); end
        checks++; if (lat !== 15) begin errors++; $display("FAIL basic_latency: got %0d want 15", lat); end
        checks++; if (!hold) begin errors++; $display("FAIL basic_hold: got unstable want stable"); end
        checks++; if (bl !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done: got %b want 1", bl); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL basic_byte: got none want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL basic_byte: got %h want %h", g, e); end end
        end
        got_q.delete();
    endtask

    task automatic test_saturate();
        int vals[3] = '{9999, 12000, 0};
        int lat; bit seen, hold, bl;
        logic [7:0] e, g;
        foreach (vals[j]) begin
            digit = 14'(vals[j]);
            push_expected(vals[j], 1'b1);
            fire();
            serve(6, 5, 1'b0, lat, seen, hold, bl);
            checks++; if (!seen) begin errors++; $display("FAIL sat_seen: value %0d got missing start", vals[j]); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); checks++;
                if (got_q.size() == 0) begin errors++; $display("FAIL sat_byte: got none want %h", e); end
                else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL sat_byte: value %0d got %h want %h", vals[j], g, e); end end
            end
            got_q.delete();
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic test_pending();
        int lat, snap; bit seen, hold, bl;
        logic [7:0] e, g;
        digit = 14'd7;
        push_expected(7, 1'b1);
        push_expected(123, 1'b1);
        fire();
        repeat (3) begin
            @(posedge clk); #1 trig = 1'b1;
            @(posedge clk); #1 trig = 1'b0;
        end
        digit = 14'd123;
        serve(12, 10, 1'b0, lat, seen, hold, bl);
        checks++; if (!seen) begin errors++; $display("FAIL pend_seen: got missing start want 12 bytes"); end
        snap = start_cnt;
        repeat (100) @(negedge clk);
        checks++; if (start_cnt !== snap) begin errors++; $display("FAIL pend_third: got %0d extra starts want 0", start_cnt - snap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_idle: got busy %b want 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL pend_byte: got none want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL pend_byte: got %h want %h", g, e); end end
        end
        got_q.delete();
    endtask

    task automatic test_stall();
        int lat, lat2; bit seen, hold, bl, seen2, hold2;
        logic [7:0] e, g;
        digit = 14'd8;
        push_expected(8, 1'b1);
        fire();
        // Two stray tx_done pulses during conversion consume four cycles.
        repeat (2) begin
            @(posedge clk); #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
        end
        serve(1, 1000, 1'b0, lat, seen, hold, bl);
        serve(5, 10, 1'b0, lat2, seen2, hold2, bl);
        checks++; if (lat !== 11) begin errors++; $display("FAIL stall_latency: got %0d want 11", lat); end
        checks++; if (!(seen && seen2)) begin errors++; $display("FAIL stall_seen: got missing start want 6 bytes"); end
        checks++; if (!(hold && hold2)) begin errors++; $display("FAIL stall_hold: got unstable want single pulse and constant data"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL stall_byte: got none want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL stall_byte: got %h want %h", g, e); end end
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        int lat, lat2; bit seen, hold, bl, seen2;
        logic [7:0] e, g;
        digit = 14'd5;
        push_expected(5, 1'b1);
        push_expected(6, 1'b1);
        fire();
        digit = 14'd6;
        serve(6, 4, 1'b1, lat, seen, hold, bl);
        serve(6, 4, 1'b0, lat2, seen2, hold, bl);
        @(negedge clk);
        checks++; if (!(seen && seen2)) begin errors++; $display("FAIL b2b_seen: got missing start want 12 bytes"); end
        checks++; if (lat2 !== 15) begin errors++; $display("FAIL b2b_restart_latency: got %0d want 15", lat2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL b2b_byte: got none want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL b2b_byte: got %h want %h", g, e); end end
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        int lat, n, snap; bit seen, hold, bl;
        logic [7:0] e, g;
        digit = 14'd1234;
        push_expected(1234, 1'b1);
        fire();
        @(posedge clk); #1 trig = 1'b1;   // leaves a pending report that reset must drop
        @(posedge clk); #1 trig = 1'b0;
        serve(3, 10, 1'b0, lat, seen, hold, bl);
        n = 0; seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            if (start) seen = 1'b1; else n++;
        end
        if (seen) got_q.push_back(data);
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_byte3_start: got none want start"); end
        repeat (5) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b want 0", start); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        snap = start_cnt;
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        repeat (200) @(negedge clk);
        checks++; if (start_cnt !== snap || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet: got %0d starts busy=%b want 0 starts busy=0", start_cnt - snap, busy);
        end
        // Only bytes 0..3 were sent before reset.
        repeat (2) void'(exp_q.pop_back());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL rstmid_byte: got none want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL rstmid_byte: got %h want %h", g, e); end end
        end
        got_q.delete();
    endtask

    task automatic test_no_crlf();
        int n; bit seen;
        logic [7:0] e, g;
        digit2 = 14'd5;
        push_expected(5, 1'b0);
        @(posedge clk); #1 trig2 = 1'b1;
        @(posedge clk); #1 trig2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = 0; seen = 1'b0;
            while (n < 100 && !seen) begin
                @(negedge clk);
                if (start2) seen = 1'b1; else n++;
            end
            if (!seen) break;
            got_q.push_back(data2);
            @(posedge clk); #1 done2 = 1'b1;
            @(posedge clk); #1 done2 = 1'b0;
        end
        @(negedge clk);
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL nocrlf_idle: got busy %b want 0", busy2); end
        repeat (50) @(negedge clk);
        checks++; if (start_cnt2 !== 4) begin errors++; $display("FAIL nocrlf_count: got %0d starts want 4", start_cnt2); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL nocrlf_byte: got none want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL nocrlf_byte: got %h want %h", g, e); end end
        end
        got_q.delete();
    endtask

    initial begin
        reset = 1'b1; trig = 1'b0; tx_done = 1'b0; digit = '0;
        trig2 = 1'b0; done2 = 1'b0; digit2 = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_pending();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_no_crlf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
